// File: rtl/gb_mem_pkg.sv
// Memory-map constants and shared types for the CPU bus responder.
// Region limits are inclusive.
package gb_mem_pkg;

   localparam logic [15:0] WRAM_BASE      = 16'hC000;
   localparam logic [15:0] WRAM_LIMIT     = 16'hDFFF;
   localparam logic [15:0] ECHO_BASE      = 16'hE000;
   localparam logic [15:0] ECHO_LIMIT     = 16'hFDFF;
   localparam logic [15:0] OAM_BASE       = 16'hFE00;
   localparam logic [15:0] OAM_LIMIT      = 16'hFE9F;
   localparam logic [15:0] UNUSABLE_BASE  = 16'hFEA0;
   localparam logic [15:0] UNUSABLE_LIMIT = 16'hFEFF;
   localparam logic [15:0] HRAM_BASE      = 16'hFF80;
   localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;
   localparam logic [15:0] DMA_ADDR       = 16'hFF46;
   localparam logic [15:0] IE_ADDR        = 16'hFFFF;
   localparam logic [7:0]  UNMAPPED_DATA  = 8'hFF;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_START,
      DMA_COPY
   } dmaState_t;

   typedef enum logic [1:0] {
      RD_REG,
      RD_WRAM,
      RD_OAM,
      RD_HRAM
   } rdSel_t;

   function automatic logic inRange(
      input logic [15:0] a,
      input logic [15:0] lo,
      input logic [15:0] hi
   );
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM with synchronous read; contents are never reset.
module sync_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] dataW,
   output logic [WIDTH-1:0] dataR
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= dataW;
      end
      dataR <= mem[addr];
   end

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: WRAM/echo, OAM, HRAM, IE and the OAM DMA engine.
// WRAM and OAM ports belong to the DMA engine while dmaActive is high.
module bus_responder
   import gb_mem_pkg::*;
#(
   parameter int DMA_BYTES = 160,
   parameter int DMA_SLOT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] memAddress,
   input  logic [7:0]  memDataW,
   input  logic        RW,
   output logic [7:0]  memDataR,
   output logic        memHit,
   output logic        dmaActive
);

   dmaState_t   dmaState;
   rdSel_t      rdSel;
   logic [7:0]  dmaBase;
   logic [7:0]  dmaIndex;
   logic [7:0]  slotCnt;
   logic [7:0]  dmaReg;
   logic [7:0]  ieReg;
   logic [7:0]  regData;
   logic [15:0] srcAddr;
   logic        srcValid;
   logic        lastSlot;
   logic        copyWrite;
   logic [7:0]  dmaByte;

   logic isWram, isOam, isUnusable;
   logic isDma, isHram, isIe, isHit;
   logic cpuBlocked;

   logic [12:0] wramAddr;
   logic        wramWe;
   logic [7:0]  wramDataR;
   logic [7:0]  oamAddr;
   logic        oamWe;
   logic [7:0]  oamDataW;
   logic [7:0]  oamDataR;
   logic        hramWe;
   logic [7:0]  hramDataR;

   assign isWram     = inRange(memAddress, WRAM_BASE, ECHO_LIMIT);
   assign isOam      = inRange(memAddress, OAM_BASE, OAM_LIMIT);
   assign isUnusable = inRange(memAddress, UNUSABLE_BASE,
                               UNUSABLE_LIMIT);
   assign isHram     = inRange(memAddress, HRAM_BASE, HRAM_LIMIT);
   assign isDma      = (memAddress == DMA_ADDR);
   assign isIe       = (memAddress == IE_ADDR);
   assign isHit      = isWram | isOam | isUnusable
                     | isDma | isHram | isIe;

   assign dmaActive  = (dmaState != DMA_IDLE);
   assign cpuBlocked = dmaActive && (memAddress < HRAM_BASE);

   // Index never carries into the base byte.
   assign srcAddr   = {dmaBase, dmaIndex};
   assign srcValid  = inRange(srcAddr, WRAM_BASE, ECHO_LIMIT);
   assign lastSlot  = (slotCnt == 8'(DMA_SLOT - 1));
   assign copyWrite = (dmaState == DMA_COPY) && (slotCnt == 8'd1);
   assign dmaByte   = srcValid ? wramDataR : UNMAPPED_DATA;

   assign wramAddr = dmaActive ? srcAddr[12:0] : memAddress[12:0];
   assign wramWe   = !dmaActive && RW && isWram;
   assign oamAddr  = dmaActive ? dmaIndex : memAddress[7:0];
   assign oamWe    = dmaActive ? copyWrite : (RW && isOam);
   assign oamDataW = dmaActive ? dmaByte : memDataW;
   assign hramWe   = RW && isHram;

   sync_ram #(.DEPTH(8192), .WIDTH(8)) wram (
      .clk   (clk),
      .we    (wramWe),
      .addr  (wramAddr),
      .dataW (memDataW),
      .dataR (wramDataR)
   );

   sync_ram #(.DEPTH(160), .WIDTH(8)) oam (
      .clk   (clk),
      .we    (oamWe),
      .addr  (oamAddr),
      .dataW (oamDataW),
      .dataR (oamDataR)
   );

   sync_ram #(.DEPTH(127), .WIDTH(8)) hram (
      .clk   (clk),
      .we    (hramWe),
      .addr  (memAddress[6:0]),
      .dataW (memDataW),
      .dataR (hramDataR)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dmaState <= DMA_IDLE;
         dmaBase  <= 8'h00;
         dmaIndex <= 8'h00;
         slotCnt  <= 8'h00;
         dmaReg   <= 8'h00;
         ieReg    <= 8'h00;
      end else begin
         if (RW && isIe) begin
            ieReg <= memDataW;
         end
         // An FF46 write always (re)starts the transfer.
         if (RW && isDma) begin
            dmaReg   <= memDataW;
            dmaBase  <= memDataW;
            dmaIndex <= 8'h00;
            slotCnt  <= 8'h00;
            dmaState <= DMA_START;
         end else begin
            unique case (dmaState)
               DMA_START: begin
                  if (lastSlot) begin
                     slotCnt  <= 8'h00;
                     dmaState <= DMA_COPY;
                  end else begin
                     slotCnt <= slotCnt + 8'd1;
                  end
               end
               DMA_COPY: begin
                  if (!lastSlot) begin
                     slotCnt <= slotCnt + 8'd1;
                  end else if (dmaIndex == 8'(DMA_BYTES - 1)) begin
                     slotCnt  <= 8'h00;
                     dmaIndex <= 8'h00;
                     dmaState <= DMA_IDLE;
                  end else begin
                     slotCnt  <= 8'h00;
                     dmaIndex <= dmaIndex + 8'd1;
                  end
               end
               default: begin
                  slotCnt <= 8'h00;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memHit  <= 1'b0;
         rdSel   <= RD_REG;
         regData <= UNMAPPED_DATA;
      end else begin
         memHit  <= isHit;
         rdSel   <= RD_REG;
         regData <= UNMAPPED_DATA;
         if (!cpuBlocked) begin
            unique case (1'b1)
               isWram:     rdSel   <= RD_WRAM;
               isOam:      rdSel   <= RD_OAM;
               isHram:     rdSel   <= RD_HRAM;
               isUnusable: regData <= 8'h00;
               isDma:      regData <= dmaReg;
               isIe:       regData <= ieReg;
               default:    regData <= UNMAPPED_DATA;
            endcase
         end
      end
   end

   always_comb begin
      memDataR = regData;
      unique case (rdSel)
         RD_WRAM: memDataR = wramDataR;
         RD_OAM:  memDataR = oamDataR;
         RD_HRAM: memDataR = hramDataR;
         default: memDataR = regData;
      endcase
   end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: vector table plus DMA sequences.
// Reads are scoreboarded and compared one clock after the address.
module tb_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] memAddress;
   logic [7:0]  memDataW;
   logic        RW;
   logic [7:0]  memDataR;
   logic        memHit;
   logic        dmaActive;

   int tests  = 0;
   int fails  = 0;
   int actCnt = 0;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic       hit;
      bit         chkHit;
   } exp_t;

   typedef struct {
      string       name;
      bit          doW;
      logic [15:0] wAddr;
      logic [7:0]  wData;
      logic [15:0] rAddr;
      logic [7:0]  eData;
      logic        eHit;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   bus_responder #(.DMA_BYTES(160), .DMA_SLOT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .memAddress (memAddress),
      .memDataW   (memDataW),
      .RW         (RW),
      .memDataR   (memDataR),
      .memHit     (memHit),
      .dmaActive  (dmaActive)
   );

   task automatic step();
      @(posedge clk);
      #1;
      if (dmaActive) actCnt++;
   endtask

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      memAddress = a;
      memDataW   = d;
      RW         = 1'b1;
      step();
      RW = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [15:0] a,
                     input logic [7:0] d, input logic h,
                     input bit ch);
      exp_t e;
      memAddress = a;
      RW         = 1'b0;
      e = '{nm, d, h, ch};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      check({e.name, " data"}, 32'(memDataR), 32'(e.data));
      if (e.chkHit) check({e.name, " hit"}, 32'(memHit), 32'(e.hit));
   endtask

   task automatic waitIdle(input string nm);
      int g = 0;
      while (dmaActive && g < 3000) begin
         step();
         g++;
      end
      check({nm, " idle timeout"}, 32'(dmaActive), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{"echo", 1, 16'hC123, 8'h5A, 16'hE123, 8'h5A, 1});
      vecs.push_back('{"unmap", 0, 16'h0000, 8'h00, 16'h8000, 8'hFF, 0});
      vecs.push_back('{"unuse", 0, 16'h0000, 8'h00, 16'hFEA5, 8'h00, 1});
      vecs.push_back('{"unusew", 1, 16'hFEA5, 8'h12, 16'hFEA5, 8'h00, 1});
      vecs.push_back('{"hramlo", 1, 16'hFF80, 8'hA5, 16'hFF80, 8'hA5, 1});
      vecs.push_back('{"hramhi", 1, 16'hFFFE, 8'h3C, 16'hFFFE, 8'h3C, 1});
      vecs.push_back('{"ie", 1, 16'hFFFF, 8'h81, 16'hFFFF, 8'h81, 1});
      vecs.push_back('{"wramhi", 1, 16'hDFFF, 8'h99, 16'hDFFF, 8'h99, 1});
      vecs.push_back('{"echohi", 1, 16'hDDFF, 8'h44, 16'hFDFF, 8'h44, 1});
      vecs.push_back('{"oamlo", 1, 16'hFE00, 8'h11, 16'hFE00, 8'h11, 1});
      vecs.push_back('{"oamhi", 1, 16'hFE9F, 8'h22, 16'hFE9F, 8'h22, 1});
      vecs.push_back('{"zero", 0, 16'h0000, 8'h00, 16'h0000, 8'hFF, 0});
      vecs.push_back('{"ff00", 0, 16'h0000, 8'h00, 16'hFF00, 8'hFF, 0});
      vecs.push_back('{"ff45", 0, 16'h0000, 8'h00, 16'hFF45, 8'hFF, 0});
      vecs.push_back('{"romw", 1, 16'h8000, 8'h33, 16'h8000, 8'hFF, 0});

      reset      = 1'b1;
      memAddress = 16'h0000;
      memDataW   = 8'h00;
      RW         = 1'b0;
      step();
      step();
      check("rst data", 32'(memDataR), 32'hFF);
      check("rst hit", 32'(memHit), 32'd0);
      check("rst dma", 32'(dmaActive), 32'd0);
      reset = 1'b0;
      step();

      foreach (vecs[k]) begin
         if (vecs[k].doW) wr(vecs[k].wAddr, vecs[k].wData);
         rd(vecs[k].name, vecs[k].rAddr, vecs[k].eData,
            vecs[k].eHit, 1'b1);
      end

      for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i) ^ 8'h3C);
      wr(16'hD000, 8'hEE);
      actCnt = 0;
      wr(16'hFF46, 8'hC0);
      check("dma rise", 32'(dmaActive), 32'd1);
      rd("dma blk", 16'hC000, 8'hFF, 1'b0, 1'b0);
      wr(16'hFF80, 8'h77);
      rd("dma hram", 16'hFF80, 8'h77, 1'b1, 1'b1);
      rd("dma ie", 16'hFFFF, 8'h81, 1'b1, 1'b1);
      wr(16'hD000, 8'h11);
      waitIdle("dma1");
      check("dma1 len", 32'(actCnt), 32'd644);
      rd("wr blocked", 16'hD000, 8'hEE, 1'b1, 1'b1);
      rd("ff46 rd", 16'hFF46, 8'hC0, 1'b1, 1'b1);
      for (int i = 0; i < 160; i++)
         rd("oam c0", 16'hFE00 + 16'(i), 8'(i) ^ 8'h3C, 1'b1, 1'b1);

      for (int i = 0; i < 160; i++)
         wr(16'hD000 + 16'(i), 8'(i * 7 + 1));
      wr(16'hFF46, 8'hC0);
      repeat (99) step();
      actCnt = 0;
      wr(16'hFF46, 8'hD0);
      waitIdle("dma2");
      check("restart len", 32'(actCnt), 32'd644);
      for (int i = 0; i < 160; i++)
         rd("oam d0", 16'hFE00 + 16'(i), 8'(i * 7 + 1), 1'b1, 1'b1);

      wr(16'hFF46, 8'h80);
      waitIdle("dma3");
      rd("src ff 0", 16'hFE00, 8'hFF, 1'b1, 1'b1);
      rd("src ff 80", 16'hFE50, 8'hFF, 1'b1, 1'b1);
      rd("src ff 9f", 16'hFE9F, 8'hFF, 1'b1, 1'b1);

      wr(16'hFF46, 8'hC0);
      repeat (299) step();
      check("pre rst act", 32'(dmaActive), 32'd1);
      reset = 1'b1;
      #1;
      check("abort dma", 32'(dmaActive), 32'd0);
      check("abort data", 32'(memDataR), 32'hFF);
      check("abort hit", 32'(memHit), 32'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      check("post rst data", 32'(memDataR), 32'hFF);
      check("post rst dma", 32'(dmaActive), 32'd0);
      rd("rst ff46", 16'hFF46, 8'h00, 1'b1, 1'b1);
      rd("rst ie", 16'hFFFF, 8'h00, 1'b1, 1'b1);
      repeat (10) step();
      check("stay idle", 32'(dmaActive), 32'd0);
      check("sb empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter DMA_BYTES, default 160, number of bytes per OAM DMA transfer.
REQ-002 SHALL have parameter DMA_SLOT, default 4, clocks per DMA byte and DMA start delay.
REQ-003 clk  in  1  single 4 MHz clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 memAddress  in  16  bus address from CPU master.
REQ-006 memDataW  in  8  write data from master.
REQ-007 RW  in  1  0 = read, 1 = write.
REQ-008 memDataR  out  8  registered read data.
REQ-009 memHit  out  1  registered: previous-cycle address decoded to this block.
REQ-010 dmaActive  out  1  high while OAM DMA is in START or COPY.

Function
REQ-011 Decode map SHALL be:
- C000-DFFF: WRAM, 8 KiB.
- E000-FDFF: echo of C000-DDFF.
- FE00-FE9F: OAM, 160 B.
- FEA0-FEFF: unusable; reads 0x00, writes ignored.
- FF46: DMA register.
- FF80-FFFE: HRAM, 127 B.
- FFFF: IE, 8 bits.
- All other addresses: memHit=0, memDataR=0xFF, writes ignored.
REQ-012 Read latency SHALL be one clock: the address sampled at edge N produces memDataR and memHit valid after edge N+1.
REQ-013 A write SHALL commit at the edge where RW=1; a read of the same address on the next cycle SHALL return the new value.
REQ-014 Reading FF46 SHALL return the last value written; reading IE SHALL return all 8 bits.
REQ-015 A write of value XX to FF46 SHALL enter START with source base XX00 and byte index 0.
REQ-016 DMA FSM SHALL have states IDLE, START and COPY:
- IDLE -> START on FF46 write.
- START -> COPY after DMA_SLOT clocks.
- COPY -> IDLE after byte DMA_BYTES-1 is written.
REQ-017 In COPY, each byte SHALL use DMA_SLOT clocks:
- slot 0: read source base+i.
- slot 1: write OAM[i].
- slots 2-3: idle.
REQ-018 Source data SHALL come from WRAM when the source address is C000-FDFF (echo-mapped); any other source SHALL write 0xFF.
REQ-019 dmaActive SHALL rise on the edge after the FF46 write and stay high exactly DMA_SLOT*(DMA_BYTES+1) = 644 clocks.
REQ-020 While dmaActive=1, CPU accesses outside FF80-FFFF SHALL read 0xFF with writes ignored; HRAM and IE SHALL operate normally.
REQ-020a As an exception to REQ-020, an FF46 write while dmaActive=1 SHALL be accepted.
REQ-021 An FF46 write during START or COPY SHALL restart the transfer: new base, index 0, state START.
REQ-022 DMA SHALL have exclusive use of the WRAM and OAM ports while in COPY; there is no CPU/DMA contention on those ports.
REQ-023 The byte index SHALL be 8 bits and the source address SHALL be {base, index}; no carry into base.

Reset
REQ-024 Reset SHALL force:
- memDataR=0xFF, memHit=0, dmaActive=0.
- DMA state IDLE, index 0, slot counter 0.
- FF46 register 0x00, IE 0x00.
REQ-025 Reset during DMA SHALL abort it immediately; OAM bytes already written are retained, unwritten bytes are undefined.
REQ-026 RAM array contents SHALL NOT be cleared by reset.

Structure
REQ-027 Shared package gb_mem_pkg SHALL hold:
- region base/limit constants.
- FF46 and FFFF addresses.
- the unmapped read value 0xFF.
- the DMA state typedef (IDLE/START/COPY).
REQ-028 WRAM, OAM and HRAM SHALL each instantiate one sub-module sync_ram: single-port, synchronous read, parameterised depth and width.

Verification
REQ-029 Write 0x5A to C123, read E123 next cycle -> memDataR=0x5A, memHit=1 one clock after the read address.
REQ-030 Read 0x8000 and FEA5 -> 0xFF with memHit=0, and 0x00 with memHit=1.
REQ-031 Fill C000-C09F with i^0x3C, write 0xC0 to FF46 -> dmaActive high 644 clocks; OAM FE00+i = i^0x3C for all i.
REQ-032 During DMA: read C000 -> 0xFF; write/read FF80=0x77 -> 0x77; write D000=0x11 -> D000 unchanged after DMA.
REQ-033 Write FF46=0xC0, then FF46=0xD0 at clock 100 -> DMA restarts; dmaActive ends 644 clocks after the second write; OAM holds D000-D09F data.
REQ-034 Assert reset at clock 300 of a DMA -> dmaActive=0, FF46 reads 0x00 and IE reads 0x00 after release, memDataR=0xFF.
